// File: rtl/input_conditioner_if.sv
// Board-pin side of the input conditioner: raw buttons/switches in, conditioned
// levels and strobes out toward the GPIO block.
interface input_conditioner_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned N_SW  = 16
);
  logic [N_BTN-1:0] btn;
  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic [N_SW-1:0]  sw_level;
  logic             sw_changed;

  // Board / GPIO consumer side
  modport master (
    output btn, sw,
    input  btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed
  );

  // Conditioner side
  modport slave (
    input  btn, sw,
    output btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects raw buttons and switches, and
// generates an auto-repeat strobe for held buttons.
module input_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_SW            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input logic               clk,
  input logic               reset,
  input_conditioner_if.slave io
);

  localparam int unsigned N_IN    = N_BTN + N_SW;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_e;

  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [N_SW-1:0]  sw_meta_q, sw_sync_q;

  logic [N_IN-1:0]  in_c;
  logic [N_IN-1:0]  d_q;
  logic [N_IN-1:0]  accept_c;
  logic [CNT_W-1:0] c_q [N_IN];
  logic [CNT_W-1:0] c_d [N_IN];

  logic [N_BTN-1:0] btn_rise_c, btn_fall_c;
  logic [N_SW-1:0]  sw_accept_c;

  logic [N_BTN-1:0] press_q, release_q, repeat_q, repeat_d;
  logic             changed_q;

  rep_state_e       rep_state_q [N_BTN];
  rep_state_e       rep_state_d [N_BTN];
  logic [REP_W-1:0] r_q [N_BTN];
  logic [REP_W-1:0] r_d [N_BTN];

  // Two-flop synchronizers; buttons idle high (released) out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= io.btn;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= io.sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Buttons are inverted here so every debouncer sees active-high sense
  assign in_c = {sw_sync_q, ~btn_sync_q};

  // Debounce: count consecutive mismatches, accept on the terminal count
  always_comb begin
    accept_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      c_d[i] = c_q[i];
      if (in_c[i] == d_q[i]) begin
        c_d[i] = '0;
      end else if (c_q[i] == DB_LAST) begin
        c_d[i]      = '0;
        accept_c[i] = 1'b1;
      end else begin
        c_d[i] = c_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
      for (int i = 0; i < N_IN; i++) c_q[i] <= '0;
    end else begin
      d_q <= d_q ^ accept_c;
      for (int i = 0; i < N_IN; i++) c_q[i] <= c_d[i];
    end
  end

  assign btn_rise_c  = accept_c[N_BTN-1:0] & ~d_q[N_BTN-1:0];
  assign btn_fall_c  = accept_c[N_BTN-1:0] &  d_q[N_BTN-1:0];
  assign sw_accept_c = accept_c[N_IN-1:N_BTN];

  // Repeat FSM next-state; a debounced release always wins and suppresses the strobe
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_state_d[i] = rep_state_q[i];
      r_d[i]         = r_q[i];
      if (btn_fall_c[i]) begin
        rep_state_d[i] = REP_IDLE;
        r_d[i]         = '0;
      end else begin
        case (rep_state_q[i])
          REP_IDLE: begin
            if (btn_rise_c[i]) begin
              rep_state_d[i] = REP_DELAY;
              r_d[i]         = '0;
            end
          end
          REP_DELAY: begin
            if (r_q[i] == DLY_LAST) begin
              repeat_d[i]    = 1'b1;
              r_d[i]         = '0;
              rep_state_d[i] = REP_RATE;
            end else begin
              r_d[i] = r_q[i] + REP_W'(1);
            end
          end
          REP_RATE: begin
            if (r_q[i] == PER_LAST) begin
              repeat_d[i] = 1'b1;
              r_d[i]      = '0;
            end else begin
              r_d[i] = r_q[i] + REP_W'(1);
            end
          end
          default: begin
            rep_state_d[i] = REP_IDLE;
            r_d[i]         = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_state_q[i] <= REP_IDLE;
        r_q[i]         <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_state_q[i] <= rep_state_d[i];
        r_q[i]         <= r_d[i];
      end
    end
  end

  // Strobes are registered on the same edge the debounced level moves
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      press_q   <= btn_rise_c;
      release_q <= btn_fall_c;
      repeat_q  <= repeat_d;
      changed_q <= |sw_accept_c;
    end
  end

  assign io.btn_level   = d_q[N_BTN-1:0];
  assign io.btn_press   = press_q;
  assign io.btn_release = release_q;
  assign io.btn_repeat  = repeat_q;
  assign io.sw_level    = d_q[N_IN-1:N_BTN];
  assign io.sw_changed  = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat constants;
// every cycle of each scenario compares the full output bundle to hand-derived values.
module tb_input_conditioner;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned N_SW  = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  input_conditioner_if #(.N_BTN(N_BTN), .N_SW(N_SW)) io ();

  input_conditioner #(
    .N_BTN(N_BTN), .N_SW(N_SW),
    .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  // {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed}
  logic [32:0] obs;
  assign obs = {io.btn_level, io.btn_press, io.btn_release, io.btn_repeat,
                io.sw_level, io.sw_changed};

  function automatic logic [32:0] mk(input logic [3:0] bl, input logic [3:0] bp,
                                     input logic [3:0] br, input logic [3:0] brp,
                                     input logic [15:0] sl, input logic sc);
    return {bl, bp, br, brp, sl, sc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] exp;
    reset  = 1'b1;
    io.btn = 4'hF;
    io.sw  = 16'h0000;
    for (int j = 0; j < 3; j++) begin
      step();
      exp = '0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [32:0] exp;
    for (int j = 0; j < 100; j++) begin
      step();
      exp = '0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL idle cyc %0d: got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_press_release();
    logic [32:0] exp;
    io.btn = 4'b1101;
    for (int j = 0; j < 15; j++) begin
      step();
      exp = mk((j >= 9) ? 4'b0010 : 4'b0000, (j == 9) ? 4'b0010 : 4'b0000,
               4'b0000, 4'b0000, 16'h0000, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL press cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    io.btn = 4'hF;
    for (int j = 0; j < 12; j++) begin
      step();
      exp = mk((j < 9) ? 4'b0010 : 4'b0000, 4'b0000,
               (j == 9) ? 4'b0010 : 4'b0000, 4'b0000, 16'h0000, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL release cyc %0d: got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [32:0] exp;
    for (int j = 0; j < 75; j++) begin
      if (j < 60) io.btn = ((j / 5) % 2 == 0) ? 4'b1011 : 4'b1111;
      else        io.btn = 4'hF;
      step();
      exp = '0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [32:0] exp;
    logic        rep;
    io.btn = 4'b1110;
    for (int j = 0; j < 10; j++) begin
      step();
      exp = mk((j >= 9) ? 4'b0001 : 4'b0000, (j == 9) ? 4'b0001 : 4'b0000,
               4'b0000, 4'b0000, 16'h0000, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL repeat_press cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    // k counts cycles after the press-strobe cycle; raw release lands so the
    // debounced release coincides with a would-be repeat at +65
    for (int k = 1; k <= 80; k++) begin
      step();
      rep = (k >= 20) && (k < 65) && ((k - 20) % 5 == 0);
      exp = mk((k < 65) ? 4'b0001 : 4'b0000, 4'b0000,
               (k == 65) ? 4'b0001 : 4'b0000, {3'b000, rep}, 16'h0000, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL repeat cyc +%0d: got %h want %h", k, obs, exp);
      end
      if (k == 55) io.btn = 4'hF;
    end
  endtask

  task automatic test_switch();
    logic [32:0] exp;
    io.sw = 16'hA5A5;
    for (int j = 0; j < 12; j++) begin
      step();
      exp = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000,
               (j >= 9) ? 16'hA5A5 : 16'h0000, j == 9);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sw_on cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    io.sw = 16'h0000;
    for (int j = 0; j < 12; j++) begin
      step();
      exp = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000,
               (j < 9) ? 16'hA5A5 : 16'h0000, j == 9);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sw_off cyc %0d: got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [32:0] exp;
    io.btn = 4'b0111;
    for (int j = 0; j < 5; j++) begin
      step();
      exp = '0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL pre_reset cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      exp = '0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_reset cyc %0d: got %h want %h", j, obs, exp);
      end
    end
    reset = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      step();
      exp = mk((j >= 10) ? 4'b1000 : 4'b0000, (j == 10) ? 4'b1000 : 4'b0000,
               4'b0000, 4'b0000, 16'h0000, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got %h want %h", j, obs, exp);
      end
    end
    io.btn = 4'hF;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_release();
    test_glitch();
    test_repeat();
    test_switch();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronizes, debounces and edge-detects the Urbana board's raw push-buttons and slide switches before they reach the MicroBlaze GPIO inputs in the top level. The block replaces the direct `sw`/`btn` wiring with clean active-high levels, one-cycle press/release strobes and an auto-repeat strobe. Software can then poll GPIO without its own debounce loops. It sits between the board pins and `mb_block`, in the 100 MHz `clk` domain.

## Interface
- `N_BTN`, 4: number of push-buttons.
- `N_SW`, 16: number of slide switches.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); minimum 2.
- `REPEAT_DELAY`, 50_000_000: cycles from press strobe to first repeat strobe.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent repeat strobes.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  N_BTN  raw buttons, active-low, asynchronous.
- `sw`  in  N_SW  raw switches, active-high, asynchronous.
- `btn_level`  out  N_BTN  debounced, active-high (1 = pressed).
- `btn_press`  out  N_BTN  one-cycle strobe on debounced press.
- `btn_release`  out  N_BTN  one-cycle strobe on debounced release.
- `btn_repeat`  out  N_BTN  one-cycle auto-repeat strobe while a button is held.
- `sw_level`  out  N_SW  debounced switch levels.
- `sw_changed`  out  1  one-cycle strobe when any bit of `sw_level` changes.

## Operation
- Each input bit passes through a 2-flop synchronizer. Button bits are inverted after the synchronizer so that internal sense is active-high.
- Each bit has an independent debouncer with stable state `d` and counter `c`, width `$clog2(DEBOUNCE_CYCLES)`:
  - sync output equals `d`: `c <= 0`.
  - Otherwise: `c <= c+1`.
  - When mismatch is sampled with `c == DEBOUNCE_CYCLES-1`: `d <=` sync output and `c <= 0`.
  - Any bounce back to `d` before acceptance clears `c`, so glitches shorter than `DEBOUNCE_CYCLES` never propagate.
- `btn_level`/`sw_level` are the registered `d` values.
- `btn_press[i]` is registered at the same edge where `d` goes 0→1, so it is high exactly in the first cycle `btn_level[i]` is 1. `btn_release[i]` behaves the same way for 1→0. Both strobes are never high together for the same bit.
- `sw_changed` is high in the first cycle after any `sw_level` bit updates. It stays a single cycle even if several bits update on the same edge.
- Auto-repeat is a per-button state machine:
  - IDLE: on press, go to DELAY with the repeat counter `r = 0`.
  - DELAY: `r++`. When `r == REPEAT_DELAY-1`, pulse `btn_repeat`, clear `r`, go to RATE.
  - RATE: `r++`. When `r == REPEAT_PERIOD-1`, pulse `btn_repeat` and clear `r`.
  - A debounced release from any state goes to IDLE and clears `r`. No repeat strobe is issued in the release cycle.
- Buttons and switches are fully independent. Simultaneous events on different bits each produce their own strobes in the same cycle.

## Timing
- Reset values:
  - Button synchronizer flops: 1 (idle, released).
  - Switch synchronizer flops: 0.
  - All `d`, `c`, `r`: 0. All repeat FSMs: IDLE.
  - All outputs: 0.
- Raw-to-level latency: a raw change captured at edge k appears on `*_level` after edge k+1+DEBOUNCE_CYCLES, provided the input stays stable throughout.
- First repeat strobe comes REPEAT_DELAY cycles after the press-strobe cycle. Later strobes come every REPEAT_PERIOD cycles.
- Reset mid-count discards all progress. Any switch that is already on at reset release is accepted after DEBOUNCE_CYCLES+2 cycles, with a `sw_changed` strobe. A button held through reset produces a normal press strobe after the debounce period.
- Counters never wrap: terminal compare always clears them.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=5`.
- Reset, then `btn=4'hF` and `sw=0` held for 100 cycles -> all outputs stay 0 throughout.
- Drive `btn[1]` low at edge 0 and hold -> `btn_level[1]` rises after edge 9. `btn_press[1]` is high for exactly that one cycle. No other bits toggle.
- Toggle `btn[2]` with 5-cycle low/high glitches for 60 cycles, then return high -> `btn_level[2]`, `btn_press[2]` and `btn_release[2]` stay 0.
- Hold `btn[0]` pressed for 60 cycles past its press strobe -> `btn_repeat[0]` pulses at +20, +25, ..., +60. Release -> `btn_release[0]` pulses once and no further repeats occur.
- Change `sw` from 16'h0000 to 16'hA5A5 at one edge -> `sw_level=16'hA5A5` after edge 9, with a single 1-cycle `sw_changed`.
- Assert `reset` 4 cycles into a debounce of `btn[3]` -> counter clears, outputs stay 0. After reset release with `btn[3]` still low, the press strobe appears 10 edges later.
